// File: rtl/csa_seq_accumulator.sv
// Multi-operand accumulator: operands are folded into redundant sum/carry
// registers by 3:2 compression, then resolved by a CHUNK-bit sliced adder.
module csa_seq_accumulator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GUARD = 8,
  parameter int unsigned CHUNK = 8,
  localparam int unsigned AW = WIDTH + GUARD
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic          in_signed_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_sum_o,
  output logic          out_ovf_o,
  output logic          busy_o
);

  localparam int unsigned NSLICE = (AW + CHUNK - 1) / CHUNK;
  localparam int unsigned PW     = NSLICE * CHUNK;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned CW     = GUARD + 1;
  localparam logic [CW-1:0] CNT_SAT = CW'(2 ** GUARD + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   s_q, c_q;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   idx_q;
  logic            cy_q;
  logic [PW-1:0]   sum_q;
  logic            ovf_q;
  logic            valid_q;

  logic            accept;
  logic [AW-1:0]   x, s_nxt, c_nxt;
  logic [CW-1:0]   count_inc;
  logic [PW-1:0]   s_pad, c_pad;
  logic [CHUNK:0]  slice_sum;

  assign in_ready_o  = ((state == IDLE) || (state == ACCUM)) && !flush_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = valid_q;
  assign out_sum_o   = sum_q[AW-1:0];
  assign out_ovf_o   = ovf_q;
  assign busy_o      = (state != IDLE);

  always_comb begin
    x = in_signed_i ? {{GUARD{in_data_i[WIDTH-1]}}, in_data_i}
                    : {{GUARD{1'b0}}, in_data_i};
    s_nxt = s_q ^ c_q ^ x;
    c_nxt = ((s_q & c_q) | (c_q & x) | (x & s_q)) << 1;
    count_inc = (count_q == CNT_SAT) ? count_q : count_q + 1'b1;
    // Pad to whole slices so a partial top slice resolves like the others.
    s_pad = PW'(s_q);
    c_pad = PW'(c_q);
    slice_sum = {1'b0, s_pad[idx_q*CHUNK +: CHUNK]}
              + {1'b0, c_pad[idx_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_q     <= x;
            c_q     <= '0;
            count_q <= CW'(1);
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            state   <= in_last_i ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            s_q     <= s_nxt;
            c_q     <= c_nxt;
            count_q <= count_inc;
            if (count_inc == CNT_SAT) ovf_q <= 1'b1;
            if (in_last_i) begin
              idx_q <= '0;
              cy_q  <= 1'b0;
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
          cy_q <= slice_sum[CHUNK];
          if (idx_q == IW'(NSLICE - 1)) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
